// File: rtl/rob_ctrl_pkg.sv
// Shared definitions for the ROB controller: FSM states, exception codes,
// privileged register indices and the pointer wrap helper.
package rob_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_NUKE      = 3'd1,
    ST_SAVE_PC   = 3'd2,
    ST_SAVE_ADDR = 3'd3,
    ST_SET_MODE  = 3'd4,
    ST_REDIRECT  = 3'd5
  } rob_state_e;

  typedef enum logic [2:0] {
    EXC_NONE      = 3'd0,
    EXC_ITLB_MISS = 3'd1,
    EXC_DTLB_MISS = 3'd2,
    EXC_ILLEGAL   = 3'd3,
    EXC_PRIV      = 3'd4,
    EXC_ALIGN     = 3'd5
  } exc_code_e;

  typedef enum logic [2:0] {
    RM0 = 3'd0,
    RM1 = 3'd1,
    RM4 = 3'd4
  } priv_idx_e;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_IRET = 1'b1
  } seq_kind_e;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;

  function automatic logic [IDX_W-1:0] rob_wrap_inc(input logic [IDX_W-1:0] ptr,
                                                    input logic [IDX_W-1:0] last);
    return (ptr == last) ? '0 : ptr + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rob_ptr_ctr.sv
// ROB head/tail/occupancy bookkeeping. Commits on an empty ROB are dropped
// here; clear has priority over any same-cycle allocate/commit.
module rob_ptr_ctr
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_i,
  input  logic             commit_i,
  input  logic             clear_i,
  output logic [IDX_W-1:0] tail_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);
  localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(ROB_SIZE);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit_ok;

  assign commit_ok = commit_i & (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_i)   tail_d = rob_wrap_inc(tail_q, LAST_IDX);
      if (commit_ok) head_d = rob_wrap_inc(head_q, LAST_IDX);
      unique case ({alloc_i, commit_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign tail_o  = tail_q;
  assign full_o  = (count_q == SIZE_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/rob_ctrl.sv
// ROB allocation control plus the exception / IRET retirement sequencer
// (nuke, privileged register saves, mode switch, fetch redirect).
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE   = 10,
  parameter logic [31:0] HANDLER_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_alloc_req,
  input  logic        in_stall,
  input  logic        in_commit,
  input  logic        in_exc_commit,
  input  logic [2:0]  in_exc_vector,
  input  logic [31:0] in_exc_pc,
  input  logic [31:0] in_exc_addr,
  input  logic        in_iret_commit,
  input  logic [31:0] in_iret_pc,
  output logic        out_alloc_grant,
  output logic [3:0]  out_alloc_idx,
  output logic        out_full,
  output logic        out_empty,
  output logic        out_nuke,
  output logic        out_priv_we,
  output logic [2:0]  out_priv_idx,
  output logic [31:0] out_priv_data,
  output logic        out_redirect,
  output logic [31:0] out_redirect_pc,
  output logic        out_busy
);

  rob_state_e  state_q;
  seq_kind_e   kind_q;
  exc_code_e   vec_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        nuke_q;
  logic        priv_we_q;
  priv_idx_e   priv_idx_q;
  logic [31:0] priv_data_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic        busy_q;

  logic        is_idle;
  logic        commit_ok;
  logic        full;
  logic        unused_vec;

  assign is_idle         = (state_q == ST_IDLE);
  assign out_alloc_grant = in_alloc_req & ~full & ~in_stall & is_idle;
  // An exception retiring the head supersedes the plain commit of that entry.
  assign commit_ok       = in_commit & ~in_exc_commit & ~in_stall & is_idle;

  rob_ptr_ctr #(
    .ROB_SIZE (ROB_SIZE)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (reset),
    .alloc_i  (out_alloc_grant),
    .commit_i (commit_ok),
    .clear_i  (state_q == ST_NUKE),
    .tail_o   (out_alloc_idx),
    .full_o   (full),
    .empty_o  (out_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_EXC;
      vec_q         <= EXC_NONE;
      pc_q          <= '0;
      addr_q        <= '0;
      nuke_q        <= 1'b0;
      priv_we_q     <= 1'b0;
      priv_idx_q    <= RM0;
      priv_data_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      nuke_q        <= 1'b0;
      priv_we_q     <= 1'b0;
      priv_idx_q    <= RM0;
      priv_data_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      // Outputs are registered, so each transition loads the pulse for the state being entered.
      unique case (state_q)
        ST_IDLE: begin
          if (in_exc_commit) begin
            vec_q   <= exc_code_e'(in_exc_vector);
            pc_q    <= in_exc_pc;
            addr_q  <= in_exc_addr;
            kind_q  <= KIND_EXC;
            state_q <= ST_NUKE;
            nuke_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (in_iret_commit) begin
            pc_q    <= in_iret_pc;
            kind_q  <= KIND_IRET;
            state_q <= ST_NUKE;
            nuke_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_NUKE: begin
          priv_we_q <= 1'b1;
          if (kind_q == KIND_EXC) begin
            state_q     <= ST_SAVE_PC;
            priv_idx_q  <= RM0;
            priv_data_q <= pc_q;
          end else begin
            state_q     <= ST_SET_MODE;
            priv_idx_q  <= RM4;
            priv_data_q <= '0;
          end
        end
        ST_SAVE_PC: begin
          state_q     <= ST_SAVE_ADDR;
          priv_we_q   <= 1'b1;
          priv_idx_q  <= RM1;
          priv_data_q <= addr_q;
        end
        ST_SAVE_ADDR: begin
          state_q     <= ST_SET_MODE;
          priv_we_q   <= 1'b1;
          priv_idx_q  <= RM4;
          priv_data_q <= (kind_q == KIND_EXC) ? 32'd1 : 32'd0;
        end
        ST_SET_MODE: begin
          state_q       <= ST_REDIRECT;
          redirect_q    <= 1'b1;
          redirect_pc_q <= (kind_q == KIND_EXC) ? HANDLER_PC : pc_q;
        end
        ST_REDIRECT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Exception code is held for debug visibility; nothing in this block consumes it.
  assign unused_vec = ^vec_q;

  assign out_full        = full;
  assign out_nuke        = nuke_q;
  assign out_priv_we     = priv_we_q;
  assign out_priv_idx    = priv_idx_q;
  assign out_priv_data   = priv_data_q;
  assign out_redirect    = redirect_q;
  assign out_redirect_pc = redirect_pc_q;
  assign out_busy        = busy_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl: allocation/commit bookkeeping,
// exception and IRET sequences, and asynchronous reset mid-sequence.
module tb_rob_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_alloc_req, in_stall, in_commit, in_exc_commit, in_iret_commit;
  logic [2:0]  in_exc_vector;
  logic [31:0] in_exc_pc, in_exc_addr, in_iret_pc;
  logic        out_alloc_grant, out_full, out_empty, out_nuke, out_priv_we;
  logic        out_redirect, out_busy;
  logic [3:0]  out_alloc_idx;
  logic [2:0]  out_priv_idx;
  logic [31:0] out_priv_data, out_redirect_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rob_ctrl #(
    .ROB_SIZE   (10),
    .HANDLER_PC (32'h0000_2000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_alloc_req    (in_alloc_req),
    .in_stall        (in_stall),
    .in_commit       (in_commit),
    .in_exc_commit   (in_exc_commit),
    .in_exc_vector   (in_exc_vector),
    .in_exc_pc       (in_exc_pc),
    .in_exc_addr     (in_exc_addr),
    .in_iret_commit  (in_iret_commit),
    .in_iret_pc      (in_iret_pc),
    .out_alloc_grant (out_alloc_grant),
    .out_alloc_idx   (out_alloc_idx),
    .out_full        (out_full),
    .out_empty       (out_empty),
    .out_nuke        (out_nuke),
    .out_priv_we     (out_priv_we),
    .out_priv_idx    (out_priv_idx),
    .out_priv_data   (out_priv_data),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc),
    .out_busy        (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " grant"},    32'(out_alloc_grant), 32'd0);
    check_eq({tag, " idx"},      32'(out_alloc_idx),   32'd0);
    check_eq({tag, " full"},     32'(out_full),        32'd0);
    check_eq({tag, " empty"},    32'(out_empty),       32'd1);
    check_eq({tag, " nuke"},     32'(out_nuke),        32'd0);
    check_eq({tag, " priv_we"},  32'(out_priv_we),     32'd0);
    check_eq({tag, " priv_idx"}, 32'(out_priv_idx),    32'd0);
    check_eq({tag, " priv_dat"}, out_priv_data,        32'd0);
    check_eq({tag, " redir"},    32'(out_redirect),    32'd0);
    check_eq({tag, " redir_pc"}, out_redirect_pc,      32'd0);
    check_eq({tag, " busy"},     32'(out_busy),        32'd0);
  endtask

  task automatic check_priv(input string tag, input logic [2:0] idx, input logic [31:0] data);
    check_eq({tag, " we"},   32'(out_priv_we),  32'd1);
    check_eq({tag, " idx"},  32'(out_priv_idx), 32'(idx));
    check_eq({tag, " data"}, out_priv_data,     data);
    check_eq({tag, " nuke"}, 32'(out_nuke),     32'd0);
  endtask

  task automatic grant_one(input string tag, input logic [3:0] exp_idx);
    in_alloc_req = 1'b1;
    #1;
    check_eq({tag, " grant"}, 32'(out_alloc_grant), 32'd1);
    check_eq({tag, " idx"},   32'(out_alloc_idx),   32'(exp_idx));
    tick();
    in_alloc_req = 1'b0;
  endtask

  task automatic commit_n(input int unsigned n);
    in_commit = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
    in_commit = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    {in_alloc_req, in_stall, in_commit, in_exc_commit, in_iret_commit} = '0;
    in_exc_vector = '0;
    in_exc_pc = '0; in_exc_addr = '0; in_iret_pc = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Stall blocks allocation
    in_alloc_req = 1'b1; in_stall = 1'b1;
    #1 check_eq("stall grant", 32'(out_alloc_grant), 32'd0);
    tick();
    check_eq("stall empty", 32'(out_empty), 32'd1);
    in_stall = 1'b0; in_alloc_req = 1'b0;

    // Fill to ROB_SIZE
    for (int unsigned i = 0; i < 10; i++) grant_one("fill", 4'(i));
    check_eq("fill full", 32'(out_full), 32'd1);
    in_alloc_req = 1'b1;
    #1 check_eq("full grant", 32'(out_alloc_grant), 32'd0);
    tick();
    in_alloc_req = 1'b0;

    // Commit 3, allocate 3: tail wraps to 0
    commit_n(3);
    check_eq("c3 full", 32'(out_full), 32'd0);
    for (int unsigned i = 0; i < 3; i++) grant_one("wrap", 4'(i));
    check_eq("wrap full", 32'(out_full), 32'd1);

    // Drain to 4 entries, then 5 cycles of simultaneous grant+commit
    commit_n(6);
    check_eq("cnt4 empty", 32'(out_empty), 32'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      in_commit = 1'b1;
      grant_one("gc", 4'(3 + i));
    end
    in_commit = 1'b0;
    commit_n(3);
    check_eq("gc 3left", 32'(out_empty), 32'd0);
    commit_n(1);
    check_eq("gc drained", 32'(out_empty), 32'd1);
    commit_n(1);
    grant_one("after empty commit", 4'd8);
    check_eq("empty commit ignored", 32'(out_empty), 32'd0);

    // Exception: vector 2, pc 0x100, addr 0xBEEF
    in_exc_commit = 1'b1; in_exc_vector = 3'b010;
    in_exc_pc = 32'h100; in_exc_addr = 32'hBEEF;
    tick();
    in_exc_commit = 1'b0; in_exc_pc = '0; in_exc_addr = '0; in_exc_vector = '0;
    check_eq("exc N1 nuke", 32'(out_nuke), 32'd1);
    check_eq("exc N1 busy", 32'(out_busy), 32'd1);
    check_eq("exc N1 we",   32'(out_priv_we), 32'd0);
    in_alloc_req = 1'b1;
    #1 check_eq("exc busy grant", 32'(out_alloc_grant), 32'd0);
    in_alloc_req = 1'b0;
    tick(); check_priv("exc N2 rm0", 3'd0, 32'h100);
    check_eq("exc N2 empty", 32'(out_empty), 32'd1);
    tick(); check_priv("exc N3 rm1", 3'd1, 32'hBEEF);
    tick(); check_priv("exc N4 rm4", 3'd4, 32'd1);
    tick();
    check_eq("exc N5 redir",    32'(out_redirect), 32'd1);
    check_eq("exc N5 redir_pc", out_redirect_pc,   32'h2000);
    check_eq("exc N5 we",       32'(out_priv_we),  32'd0);
    tick();
    check_eq("exc N6 busy",  32'(out_busy),     32'd0);
    check_eq("exc N6 redir", 32'(out_redirect), 32'd0);
    grant_one("post exc", 4'd0);

    // IRET together with exception: exception wins
    in_exc_commit = 1'b1; in_exc_pc = 32'h200; in_exc_addr = 32'h44;
    in_iret_commit = 1'b1; in_iret_pc = 32'h340;
    tick();
    in_exc_commit = 1'b0; in_iret_commit = 1'b0;
    check_eq("both N1 nuke", 32'(out_nuke), 32'd1);
    tick(); check_priv("both N2 rm0", 3'd0, 32'h200);
    tick(); check_priv("both N3 rm1", 3'd1, 32'h44);
    tick(); check_priv("both N4 rm4", 3'd4, 32'd1);
    tick();
    check_eq("both N5 redir_pc", out_redirect_pc, 32'h2000);
    tick();

    // Lone IRET
    in_iret_commit = 1'b1;
    tick();
    in_iret_commit = 1'b0; in_iret_pc = '0;
    check_eq("iret N1 nuke", 32'(out_nuke), 32'd1);
    tick(); check_priv("iret N2 rm4", 3'd4, 32'd0);
    tick();
    check_eq("iret N3 redir",    32'(out_redirect), 32'd1);
    check_eq("iret N3 redir_pc", out_redirect_pc,   32'h340);
    tick();
    check_eq("iret N4 busy", 32'(out_busy), 32'd0);

    // Reset asserted while in SAVE_ADDR
    in_exc_commit = 1'b1; in_exc_pc = 32'h500; in_exc_addr = 32'h600;
    tick();
    in_exc_commit = 1'b0;
    tick(); tick();
    check_priv("mid rm1", 3'd1, 32'h600);
    reset = 1'b0;
    #1 check_reset_outputs("async rst");
    tick();
    reset = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_eq("post rst we",    32'(out_priv_we),  32'd0);
      check_eq("post rst redir", 32'(out_redirect), 32'd0);
    end
    check_eq("post rst busy", 32'(out_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 The block SHALL have parameter ROB_SIZE, default 10, number of ROB entries (2..16).
REQ-002 The block SHALL have parameter HANDLER_PC, default 32'h0000_2000, exception handler entry PC.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0); one clock domain, no other reset.
REQ-005 in_alloc_req  in  1  decode requests one ROB entry this cycle.
REQ-006 in_stall  in  1  pipeline stall; blocks allocation and commit bookkeeping.
REQ-007 in_commit  in  1  ROB retired its head entry normally this cycle.
REQ-008 in_exc_commit  in  1  head entry retires with a nonzero exception.
REQ-009 in_exc_vector  in  3  exception code of that head entry.
REQ-010 in_exc_pc  in  32  PC of the excepting entry.
REQ-011 in_exc_addr  in  32  faulting address (ITLB: PC; DTLB: data address).
REQ-012 in_iret_commit / in_iret_pc  in  1 / 32  IRET retires; return PC.
REQ-013 out_alloc_grant  out  1  entry granted this cycle.
REQ-014 out_alloc_idx  out  4  tail index; valid when grant=1.
REQ-015 out_full / out_empty  out  1 / 1  count==ROB_SIZE / count==0.
REQ-016 out_nuke  out  1  one-cycle ROB invalidate pulse.
REQ-017 out_priv_we / out_priv_idx / out_priv_data  out  1 / 3 / 32  privileged register write port.
REQ-018 out_redirect / out_redirect_pc  out  1 / 32  one-cycle fetch redirect.
REQ-019 out_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-020 out_alloc_grant SHALL equal in_alloc_req & !out_full & !in_stall & (state==IDLE), combinationally.
REQ-021 On grant, tail SHALL advance by 1, wrapping from ROB_SIZE-1 to 0; out_alloc_idx SHALL equal the pre-advance tail.
REQ-022 in_commit with !in_stall and count>0 SHALL advance head with the same wrap rule; in_commit while empty SHALL be ignored.
REQ-023 Grant and commit in the same cycle SHALL leave count unchanged; grant alone +1; commit alone -1.
REQ-024 FSM states: IDLE, NUKE, SAVE_PC, SAVE_ADDR, SET_MODE, REDIRECT; each non-IDLE state SHALL last exactly one cycle.
REQ-025 In IDLE, in_exc_commit SHALL latch vector/pc/addr, set kind=EXC, and go to NUKE; it SHALL override in_iret_commit and in_commit in the same cycle.
REQ-026 In IDLE, in_iret_commit (no exception) SHALL latch in_iret_pc, set kind=IRET, and go to NUKE.
REQ-027 NUKE: out_nuke=1; head, tail, and count SHALL be cleared to 0 at the end of the cycle; next state SHALL be SAVE_PC for EXC, SET_MODE for IRET.
REQ-028 SAVE_PC: priv write rm0 (idx 0) = latched pc; next SAVE_ADDR.
REQ-029 SAVE_ADDR: priv write rm1 (idx 1) = latched addr; next SET_MODE.
REQ-030 SET_MODE: priv write rm4 (idx 4), data 1 for EXC and 0 for IRET; next REDIRECT.
REQ-031 REDIRECT: out_redirect=1, out_redirect_pc = HANDLER_PC (EXC) or the latched return PC (IRET); next IDLE.
REQ-032 Commit, exception, and IRET inputs SHALL be ignored while out_busy=1; in_stall SHALL NOT pause the FSM.
REQ-033 Latency: the exception commit cycle is N; out_nuke is at N+1, priv writes at N+2..N+4, and redirect at N+5 (IRET: nuke N+1, rm4 N+2, redirect N+3).

Reset
REQ-034 Asserting reset SHALL immediately force state=IDLE, head=tail=count=0, and all latches 0, including mid-sequence.
REQ-035 Reset values SHALL be: out_empty=1; every other output 0.

Structure
REQ-036 FSM state enum, exception codes, and priv register indices (RM0=0, RM1=1, RM4=4) SHALL reside in the shared defines package.
REQ-037 The head/tail/count bookkeeping SHALL be a sub-module rob_ptr_ctr; the FSM stays in rob_ctrl.

Verification
REQ-038 After reset, issue 10 grants with ROB_SIZE=10 -> indices 0..9, out_full=1, 11th request not granted.
REQ-039 Fill 10, commit 3, allocate 3 -> indices 0,1,2 (wrap), out_full=1 again.
REQ-040 count=4, grant+commit same cycle for 5 cycles -> count stays 4, tail advances 5 mod 10.
REQ-041 exc_commit vector=3'b010, pc=0x100, addr=0xBEEF -> nuke at N+1; rm0=0x100, rm1=0xBEEF, rm4=1 at N+2..N+4; redirect to 0x2000 at N+5; count=0.
REQ-042 iret_commit pc=0x340 together with exc_commit -> exception sequence only; later lone iret -> nuke, rm4=0, redirect 0x340.
REQ-043 reset asserted during SAVE_ADDR -> all outputs immediately take reset values, no further priv writes.
